// File: rtl/udc_pkg.sv
// udc_pkg: shared register addresses, status codes and FSM encoding for the counter job sequencer.
package udc_pkg;

    localparam logic [1:0] ADDR_PLR = 2'd0;
    localparam logic [1:0] ADDR_ULR = 2'd1;
    localparam logic [1:0] ADDR_LLR = 2'd2;
    localparam logic [1:0] ADDR_CCR = 2'd3;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_PARAM   = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;
    localparam logic [1:0] ST_RBACK   = 2'b11;

    // WR and RD groups sit on 4-aligned codes so the low two bits are the register address.
    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_PCHK   = 4'd1,
        S_CLR    = 4'd2,
        S_CHK    = 4'd3,
        S_WR_PLR = 4'd4,
        S_WR_ULR = 4'd5,
        S_WR_LLR = 4'd6,
        S_WR_CCR = 4'd7,
        S_RD_PLR = 4'd8,
        S_RD_ULR = 4'd9,
        S_RD_LLR = 4'd10,
        S_RD_CCR = 4'd11,
        S_START  = 4'd12,
        S_RUN    = 4'd13,
        S_FIN    = 4'd14
    } state_t;

endpackage

// File: rtl/udc_bus_cycle.sv
// udc_bus_cycle: one 2-cycle counter bus access (strobe cycle, then recovery/sample cycle) while go is held.
module udc_bus_cycle (
    input  logic       clk,
    input  logic       reset,
    input  logic       go,
    input  logic       rw,
    input  logic [1:0] addr,
    input  logic [7:0] wdata,
    input  logic [7:0] din,
    output logic       ncs,
    output logic       nwr,
    output logic       nrd,
    output logic [1:0] a,
    output logic [7:0] dout,
    output logic       dout_oe,
    output logic [7:0] rdata,
    output logic       ack
);

    logic phase_q, phase_d;

    always_comb begin
        phase_d = go && !phase_q;
        ack     = go && phase_q;
        // Reads keep chip select low through the sample cycle; writes release it for recovery.
        ncs     = !(go && (!phase_q || rw));
        nwr     = !(go && !phase_q && !rw);
        nrd     = !(go && !phase_q && rw);
        dout_oe = go && !phase_q && !rw;
        dout    = dout_oe ? wdata : 8'h00;
        a       = go ? addr : 2'b00;
        rdata   = din;
    end

    always_ff @(posedge clk) begin
        if (reset) phase_q <= 1'b0;
        else       phase_q <= phase_d;
    end

endmodule

// File: rtl/udc_job_sequencer.sv
// udc_job_sequencer: runs one clear/program/start/run job on the up/down counter bus and reports status.
// Optional register read-back verification is enabled by defining UDC_READBACK_VERIFY_EN.
module udc_job_sequencer
    import udc_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_W          = 13
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [7:0] req_plr,
    input  logic [7:0] req_ulr,
    input  logic [7:0] req_llr,
    input  logic [7:0] req_ccr,
    output logic       busy,
    output logic       done,
    output logic [1:0] status,
    output logic       ncs,
    output logic       nwr,
    output logic       nrd,
    output logic       a1,
    output logic       a0,
    output logic [7:0] dout,
    output logic       dout_oe,
    input  logic [7:0] din,
    output logic       start_out,
    output logic       cnt_rst_n,
    input  logic       cnt_err,
    input  logic       cnt_ec
);

`ifdef UDC_READBACK_VERIFY_EN
    localparam bit RB_EN = 1'b1;
`else
    localparam bit RB_EN = 1'b0;
`endif

    state_t           state_q, state_d;
    logic [3:0][7:0]  job_q, job_d;
    logic [1:0]       status_q, status_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             bus_go, bus_rw, bus_ack, bus_ncs;
    logic [1:0]       bus_a;
    logic [7:0]       bus_rdata;

    udc_bus_cycle u_bus (
        .clk     (clk),
        .reset   (reset),
        .go      (bus_go),
        .rw      (bus_rw),
        .addr    (state_q[1:0]),
        .wdata   (job_q[state_q[1:0]]),
        .din     (din),
        .ncs     (bus_ncs),
        .nwr     (nwr),
        .nrd     (nrd),
        .a       (bus_a),
        .dout    (dout),
        .dout_oe (dout_oe),
        .rdata   (bus_rdata),
        .ack     (bus_ack)
    );

    always_comb begin
        state_d  = state_q;
        job_d    = job_q;
        status_d = status_q;
        timer_d  = '0;
        bus_go   = 1'b0;
        bus_rw   = 1'b0;
        case (state_q)
            S_IDLE: if (req_valid) begin
                state_d = S_PCHK;
                job_d   = {req_ccr, req_llr, req_ulr, req_plr};
            end
            S_PCHK: if (job_q[ADDR_PLR] < job_q[ADDR_LLR] || job_q[ADDR_PLR] > job_q[ADDR_ULR]) begin
                state_d  = S_FIN;
                status_d = ST_PARAM;
            end else state_d = S_CLR;
            S_CLR: state_d = S_WR_PLR;
            S_WR_PLR, S_WR_ULR, S_WR_LLR, S_WR_CCR: begin
                bus_go = 1'b1;
                if (bus_ack) state_d = state_q != S_WR_CCR ? state_t'(state_q + 4'd1) : RB_EN ? S_RD_PLR : S_CHK;
            end
            S_RD_PLR, S_RD_ULR, S_RD_LLR, S_RD_CCR: begin
                bus_go = 1'b1;
                bus_rw = 1'b1;
                if (bus_ack && bus_rdata != job_q[state_q[1:0]]) begin
                    state_d  = S_FIN;
                    status_d = ST_RBACK;
                end else if (bus_ack) state_d = state_q != S_RD_CCR ? state_t'(state_q + 4'd1) : S_CHK;
            end
            S_CHK: begin
                timer_d = timer_q + CNT_W'(1);
                if (timer_q[0]) begin
                    state_d  = cnt_err ? S_FIN : S_START;
                    status_d = cnt_err ? ST_PARAM : status_q;
                end
            end
            S_START: state_d = S_RUN;
            S_RUN: begin
                timer_d = timer_q + CNT_W'(1);
                if (cnt_ec) begin
                    state_d  = S_FIN;
                    status_d = ST_OK;
                end else if (timer_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d  = S_FIN;
                    status_d = ST_TIMEOUT;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = state_q == S_IDLE && !reset;
        busy      = state_q != S_IDLE;
        done      = state_q == S_FIN;
        status    = status_q;
        ncs       = state_q inside {S_CLR, S_CHK, S_START, S_RUN} ? 1'b0 : bus_ncs;
        {a1, a0}  = bus_a;
        start_out = state_q == S_START;
        // A timed-out job also resets the counter during the completion cycle.
        cnt_rst_n = !(state_q == S_CLR || (state_q == S_FIN && status_q == ST_TIMEOUT));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            job_q    <= '0;
            status_q <= ST_OK;
            timer_q  <= '0;
        end else begin
            state_q  <= state_d;
            job_q    <= job_d;
            status_q <= status_d;
            timer_q  <= timer_d;
        end
    end

endmodule

// File: tb/tb_udc_job_sequencer.sv
// tb_udc_job_sequencer: scoreboard bench with a simple counter register model on the bus.
module tb_udc_job_sequencer;

`ifdef UDC_READBACK_VERIFY_EN
    localparam int START_CYC = 21;
`else
    localparam int START_CYC = 13;
`endif
    localparam int TMO = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0, req_ready;
    logic [7:0] req_plr = '0, req_ulr = '0, req_llr = '0, req_ccr = '0;
    logic       busy, done;
    logic [1:0] status;
    logic       ncs, nwr, nrd, a1, a0, dout_oe, start_out, cnt_rst_n;
    logic [7:0] dout, din;
    logic       cnt_err = 1'b0, cnt_ec = 1'b0;

    int          checks = 0, failures = 0, cyc_g = 0;
    logic [10:0] wr_exp[$], wr_obs[$];
    logic [7:0]  model_regs [4] = '{default: 8'h00};
    logic        rb_fault = 1'b0;

    udc_job_sequencer #(.TIMEOUT_CYCLES(TMO), .CNT_W(5)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_plr(req_plr), .req_ulr(req_ulr), .req_llr(req_llr), .req_ccr(req_ccr),
        .busy(busy), .done(done), .status(status),
        .ncs(ncs), .nwr(nwr), .nrd(nrd), .a1(a1), .a0(a0),
        .dout(dout), .dout_oe(dout_oe), .din(din),
        .start_out(start_out), .cnt_rst_n(cnt_rst_n), .cnt_err(cnt_err), .cnt_ec(cnt_ec)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_g <= cyc_g + 1;

    always @(negedge clk) if (!ncs && !nwr) begin
        wr_obs.push_back({dout_oe, a1, a0, dout});
        model_regs[{a1, a0}] <= dout;
    end

    always_comb din = (rb_fault && {a1, a0} == 2'd1) ? 8'h0F : model_regs[{a1, a0}];

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_job(input logic [7:0] p, u, l, c, input int ec_after, input bit hold,
                          output int acc_cyc, output int start_cyc, output int done_cyc,
                          output logic [1:0] st, output bit ncs_low, output bit rst_fin, output bit busy_fin);
        int n;
        req_plr = p; req_ulr = u; req_llr = l; req_ccr = c; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 100) begin @(negedge clk); n++; end
        acc_cyc = cyc_g;
        if (!(p < l || p > u)) begin
            wr_exp.push_back({1'b1, 2'd0, p});
            wr_exp.push_back({1'b1, 2'd1, u});
            wr_exp.push_back({1'b1, 2'd2, l});
            wr_exp.push_back({1'b1, 2'd3, c});
        end
        start_cyc = -1; done_cyc = -1; st = 2'bxx; ncs_low = 0; rst_fin = 0; busy_fin = 0;
        @(negedge clk);
        if (hold) begin req_plr = 8'hEE; req_ulr = 8'hEE; req_llr = 8'hEE; req_ccr = 8'hEE; end
        else req_valid = 1'b0;
        for (int k = 1; k < 200; k++) begin
            if (!ncs) ncs_low = 1;
            if (start_out && start_cyc < 0) start_cyc = k;
            cnt_ec = start_cyc >= 0 && ec_after >= 0 && k == start_cyc + ec_after;
            if (done) begin
                done_cyc = k; st = status; rst_fin = !cnt_rst_n; busy_fin = busy; cnt_ec = 1'b0;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if ({ncs, nwr, nrd, cnt_rst_n} !== 4'b1111) begin failures++; $display("FAIL reset_strobes: got %b expected 1111", {ncs, nwr, nrd, cnt_rst_n}); end
        checks++; if ({start_out, dout_oe, a1, a0} !== 4'b0000) begin failures++; $display("FAIL reset_ctrl: got %b expected 0000", {start_out, dout_oe, a1, a0}); end
        checks++; if (dout !== 8'h00) begin failures++; $display("FAIL reset_dout: got %h expected 00", dout); end
        checks++; if ({req_ready, busy, done} !== 3'b000) begin failures++; $display("FAIL reset_hs: got %b expected 000", {req_ready, busy, done}); end
        checks++; if (status !== 2'b00) begin failures++; $display("FAIL reset_status: got %b expected 00", status); end
        reset = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
        @(negedge clk);
    endtask

    task automatic test_normal;
        logic [7:0] pv[3] = '{8'd5, 8'h80, 8'd7};
        logic [7:0] uv[3] = '{8'd10, 8'hFF, 8'd7};
        logic [7:0] lv[3] = '{8'd2, 8'h00, 8'd7};
        logic [7:0] cv[3] = '{8'd1, 8'h00, 8'd9};
        int acc, sc, dc; logic [1:0] st; bit nl, rf, bf;
        logic [10:0] ew, gw;
        for (int j = 0; j < 3; j++) begin
            do_job(pv[j], uv[j], lv[j], cv[j], 1, 0, acc, sc, dc, st, nl, rf, bf);
            checks++; if (sc !== START_CYC) begin failures++; $display("FAIL normal%0d_start: got %0d expected %0d", j, sc, START_CYC); end
            checks++; if (dc !== START_CYC + 2) begin failures++; $display("FAIL normal%0d_done: got %0d expected %0d", j, dc, START_CYC + 2); end
            checks++; if (st !== 2'b00) begin failures++; $display("FAIL normal%0d_status: got %b expected 00", j, st); end
            checks++; if (bf !== 1'b1 || rf !== 1'b0) begin failures++; $display("FAIL normal%0d_busy_rst: got busy=%b rstfin=%b expected 1 0", j, bf, rf); end
            while (wr_exp.size() > 0) begin
                ew = wr_exp.pop_front();
                gw = wr_obs.size() > 0 ? wr_obs.pop_front() : 11'bx;
                checks++; if (gw !== ew) begin failures++; $display("FAIL normal%0d_write: got %h expected %h", j, gw, ew); end
            end
            checks++; if (wr_obs.size() != 0) begin failures++; $display("FAIL normal%0d_extra_writes: got %0d expected 0", j, wr_obs.size()); wr_obs.delete(); end
        end
        @(negedge clk);
    endtask

    task automatic test_param_err;
        logic [7:0] pv[2] = '{8'd1, 8'd1};
        logic [7:0] uv[2] = '{8'd0, 8'd9};
        logic [7:0] lv[2] = '{8'd0, 8'd2};
        int acc, sc, dc; logic [1:0] st; bit nl, rf, bf;
        for (int j = 0; j < 2; j++) begin
            do_job(pv[j], uv[j], lv[j], 8'h33, -1, 0, acc, sc, dc, st, nl, rf, bf);
            checks++; if (dc !== 2) begin failures++; $display("FAIL perr%0d_done: got %0d expected 2", j, dc); end
            checks++; if (st !== 2'b01) begin failures++; $display("FAIL perr%0d_status: got %b expected 01", j, st); end
            checks++; if (nl !== 1'b0) begin failures++; $display("FAIL perr%0d_ncs: got ncs_low=%b expected 0", j, nl); end
            checks++; if (wr_obs.size() != 0) begin failures++; $display("FAIL perr%0d_writes: got %0d expected 0", j, wr_obs.size()); wr_obs.delete(); end
        end
        @(negedge clk);
    endtask

    task automatic test_timeout;
        int acc, sc, dc; logic [1:0] st; bit nl, rf, bf;
        logic [10:0] ew, gw;
        do_job(8'd5, 8'd10, 8'd2, 8'd1, -1, 0, acc, sc, dc, st, nl, rf, bf);
        checks++; if (dc !== START_CYC + TMO + 1) begin failures++; $display("FAIL tmo_done: got %0d expected %0d", dc, START_CYC + TMO + 1); end
        checks++; if (st !== 2'b10) begin failures++; $display("FAIL tmo_status: got %b expected 10", st); end
        checks++; if (rf !== 1'b1) begin failures++; $display("FAIL tmo_cnt_rst: got rst_low=%b expected 1", rf); end
        while (wr_exp.size() > 0) begin
            ew = wr_exp.pop_front();
            gw = wr_obs.size() > 0 ? wr_obs.pop_front() : 11'bx;
            checks++; if (gw !== ew) begin failures++; $display("FAIL tmo_write: got %h expected %h", gw, ew); end
        end
        @(negedge clk);
        checks++; if ({status, done, busy, req_ready, cnt_rst_n} !== 6'b100011) begin failures++; $display("FAIL tmo_hold: got %b expected 100011", {status, done, busy, req_ready, cnt_rst_n}); end
    endtask

    task automatic test_reset_mid;
        req_plr = 8'd5; req_ulr = 8'd10; req_llr = 8'd2; req_ccr = 8'd1; req_valid = 1'b1;
        for (int n = 0; n < 100 && !req_ready; n++) @(negedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if ({nwr, a1, a0} !== 3'b001) begin failures++; $display("FAIL rmid_in_wr_ulr: got %b expected 001", {nwr, a1, a0}); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if ({ncs, nwr, req_ready, done, busy} !== 5'b11100) begin failures++; $display("FAIL rmid_idle: got %b expected 11100", {ncs, nwr, req_ready, done, busy}); end
        checks++; if (status !== 2'b00) begin failures++; $display("FAIL rmid_status: got %b expected 00", status); end
        repeat (3) @(negedge clk);
        checks++; if (done !== 1'b0 || ncs !== 1'b1) begin failures++; $display("FAIL rmid_quiet: got done=%b ncs=%b expected 0 1", done, ncs); end
        wr_obs.delete();
    endtask

`ifdef UDC_READBACK_VERIFY_EN
    task automatic test_readback;
        int acc, sc, dc; logic [1:0] st; bit nl, rf, bf;
        logic [10:0] ew, gw;
        rb_fault = 1'b1;
        do_job(8'd5, 8'h10, 8'd2, 8'd3, 1, 0, acc, sc, dc, st, nl, rf, bf);
        rb_fault = 1'b0;
        checks++; if (st !== 2'b11) begin failures++; $display("FAIL rb_status: got %b expected 11", st); end
        checks++; if (sc !== -1) begin failures++; $display("FAIL rb_no_start: got start cycle %0d expected none", sc); end
        checks++; if (dc !== 15) begin failures++; $display("FAIL rb_done: got %0d expected 15", dc); end
        while (wr_exp.size() > 0) begin
            ew = wr_exp.pop_front();
            gw = wr_obs.size() > 0 ? wr_obs.pop_front() : 11'bx;
            checks++; if (gw !== ew) begin failures++; $display("FAIL rb_write: got %h expected %h", gw, ew); end
        end
        @(negedge clk);
    endtask
`endif

    task automatic test_back_to_back;
        int acc1, acc2, sc, dc1, dc2; logic [1:0] st1, st2; bit nl, rf, bf;
        logic [10:0] ew, gw;
        do_job(8'd3, 8'd9, 8'd1, 8'd2, 1, 1, acc1, sc, dc1, st1, nl, rf, bf);
        do_job(8'd4, 8'd8, 8'd0, 8'd5, 1, 0, acc2, sc, dc2, st2, nl, rf, bf);
        checks++; if (acc2 !== acc1 + dc1 + 1) begin failures++; $display("FAIL b2b_accept: got %0d expected %0d", acc2, acc1 + dc1 + 1); end
        checks++; if ({st1, st2} !== 4'b0000) begin failures++; $display("FAIL b2b_status: got %b expected 0000", {st1, st2}); end
        checks++; if (dc2 !== START_CYC + 2) begin failures++; $display("FAIL b2b_done2: got %0d expected %0d", dc2, START_CYC + 2); end
        while (wr_exp.size() > 0) begin
            ew = wr_exp.pop_front();
            gw = wr_obs.size() > 0 ? wr_obs.pop_front() : 11'bx;
            checks++; if (gw !== ew) begin failures++; $display("FAIL b2b_write: got %h expected %h", gw, ew); end
        end
        checks++; if (wr_obs.size() != 0) begin failures++; $display("FAIL b2b_extra_writes: got %0d expected 0", wr_obs.size()); end
        @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_normal;
        test_param_err;
        test_timeout;
        test_reset_mid;
`ifdef UDC_READBACK_VERIFY_EN
        test_readback;
`endif
        test_back_to_back;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
